wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback collector directly upstream of the 4-read/4-write register file.
- Four execution-unit result channels push (register index, data) into per-channel FIFOs.
- A round-robin arbiter drains them at one committed write per cycle into a single register-file write port. This matches the register file's one-commit-per-cycle behaviour, so no result is silently dropped by its write-port priority.
- Intended hookup: outputs drive the register file's write0/writeEnable0/dataIn0. Write ports 1-3 are tied off with enables held at 0.

Parameters:
- DEPTH, 4, entries per channel FIFO; power of two, minimum 2.
- AW, 5, register index width.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rstN  input  1  synchronous active-low reset, sampled on posedge clk.
- inValid  input  4  per-channel result valid; bit i is channel i.
- inReady  output  4  per-channel accept; bit i = channel i FIFO not full.
- inAddr  input  4*AW  channel i destination index at bits [i*AW +: AW].
- inData  input  4*DW  channel i result at bits [i*DW +: DW].
- wrEnable  output  1  register-file write enable (registered).
- wrAddr  output  AW  register-file write index (registered).
- wrData  output  DW  register-file write data (registered).
- grant  output  4  one-hot channel popped last cycle (registered); 0 when idle.
- busy  output  1  any FIFO non-empty or wrEnable high.

Behaviour:
- Reset (rstN=0 at posedge)
  - All FIFOs emptied; read/write pointers and counts cleared.
  - Round-robin pointer = 0.
  - wrEnable=0, wrAddr=0, wrData=0, grant=0.
  - While rstN=0, inReady=0 and nothing is accepted. Reset mid-traffic discards all queued entries.
- Accept
  - Channel i transfers on a posedge where inValid[i] && inReady[i].
  - inReady[i] is a combinational function of FIFO i count only: inReady[i] = (count_i != DEPTH) && rstN. It never depends on inValid.
  - Order within a channel is preserved. There is no ordering guarantee across channels.
- No fall-through
  - An entry pushed at edge N is eligible for arbitration in the cycle after edge N. It is popped at earliest edge N+1.
  - wrEnable for that entry is therefore high during the cycle following edge N+1, giving a minimum accept-to-write latency of 2 edges.
- Arbitration (combinational request = FIFO non-empty)
  - Search order starts at the rr pointer: p, p+1, ... mod 4. The first non-empty channel k is granted.
  - Channel k's head is popped at the next edge, and wrAddr/wrData/grant load from that head.
  - rr pointer becomes (k+1) mod 4. It is unchanged when there are no requests.
  - At most one pop per cycle.
- Register x0
  - A popped entry with addr==0 consumes its slot: grant is set, wrAddr/wrData load.
  - wrEnable is forced to 0.
- Idle cycle: wrEnable=0 and grant=0. wrAddr/wrData hold their previous values.
- Full channel
  - inReady=0 for that channel.
  - A pop from that channel at edge N raises inReady in the cycle after edge N. There is no same-cycle pop-to-push pass-through.
- Simultaneous push and pop on the same channel, non-full: count unchanged, both operations take effect.
- Fairness: with all four channels continuously non-empty, the grant sequence is 0,1,2,3,0,... Each channel is guaranteed a slot within 4 cycles of reaching head.
- busy is combinational.

Optional Feature:
- Macro: WB_ARBITER_FWD_EN.
- Defined
  - Adds input fwdAddr (4*AW) and outputs fwdHit (4) and fwdData (4*DW).
  - fwdHit[j] = wrEnable && (wrAddr == fwdAddr[j*AW +: AW]) && (fwdAddr slice != 0). This is combinational from the registered outputs.
  - fwdData[j] = wrData when fwdHit[j], else 0.
  - Purpose: lets decode bypass the register file's registered read, since a same-cycle write is not yet visible there.
- Undefined: these ports do not exist and no compare logic is built. All other behaviour is identical.

Test Plan:
- Reset/latency: hold rstN=0 for 2 cycles, expecting all outputs 0 and inReady=0. Release, then push ch2 {addr=7, data=0xDEADBEEF} at edge N. Expect wrEnable=1, wrAddr=7, wrData=0xDEADBEEF, grant=4'b0100 after edge N+1, and wrEnable=0 after edge N+2.
- Round-robin: preload 2 entries in each channel, all at the same edge. Expect grant sequence 0001,0010,0100,1000,0001,0010,0100,1000 over 8 consecutive cycles, then wrEnable=0 and busy=0.
- Full/backpressure (DEPTH=4): push 4 entries to ch0 while ch1-3 are busy and pinned ahead. Expect inReady[0]=0. A 5th inValid is not accepted. After ch0's first pop, inReady[0]=1 one cycle later. All four ch0 entries emerge in push order.
- x0 drop: push ch1 {addr=0, data=0x1234}, then {addr=3, data=0x55}. Expect one cycle with grant=0010 and wrEnable=0, followed by wrEnable=1, wrAddr=3, wrData=0x55.
- Reset mid-operation: fill ch0 and ch3 with 3 entries each, pop one, then assert rstN=0 for 1 cycle. After release expect busy=0, no further wrEnable, rr pointer=0 (the next single push on ch3 and ch0 at the same edge grants ch0 first).
- WB_ARBITER_FWD_EN: while wrEnable=1, wrAddr=9, wrData=0xA5A5A5A5, drive fwdAddr slots = {9, 0, 9, 4}. Expect fwdHit=4'b0101 and fwdData for slots 0 and 2 = 0xA5A5A5A5, others 0. Repeat with wrAddr=0 pop, expecting fwdHit=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter -- writeback collector in front of the register file write port.
//
// Four execution-unit result channels push (index, data) pairs into private
// FIFOs. A round-robin arbiter pops at most one FIFO head per cycle and
// presents it as a registered register-file write. An entry accepted at
// edge N can be popped at edge N+1 at the earliest. There is no fall-through.
// Writes to x0 still use their slot, but they leave wrEnable low.
//
// Parameters:
//   DEPTH  entries per channel FIFO (power of two, >= 2)
//   AW     register index width
//   DW     register data width
//
// Ports:
//   clk       system clock, all state on posedge
//   rstN      synchronous active-low reset
//   inValid   per-channel result valid (bit i = channel i)
//   inReady   per-channel accept, high while FIFO i is not full and out of reset
//   inAddr    channel i destination index at [i*AW +: AW]
//   inData    channel i result at [i*DW +: DW]
//   wrEnable  registered register-file write enable
//   wrAddr    registered register-file write index
//   wrData    registered register-file write data
//   grant     registered one-hot of the channel popped last edge, 0 when idle
//   busy      any FIFO non-empty or a write in flight
//
// Optional feature, enabled by defining WB_ARBITER_FWD_EN:
//   fwdAddr   four decode-side read indices, slot j at [j*AW +: AW]
//   fwdHit    slot j matches the write currently presented (never for x0)
//   fwdData   wrData for hitting slots, 0 otherwise
// This lets decode bypass the register file's registered read while the
// same-cycle write is not yet visible there.

module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [3:0]        inValid,
    output logic [3:0]        inReady,
    input  logic [4*AW-1:0]   inAddr,
    input  logic [4*DW-1:0]   inData,
    output logic              wrEnable,
    output logic [AW-1:0]     wrAddr,
    output logic [DW-1:0]     wrData,
    output logic [3:0]        grant,
    output logic              busy
`ifdef WB_ARBITER_FWD_EN
    ,
    input  logic [4*AW-1:0]   fwdAddr,
    output logic [3:0]        fwdHit,
    output logic [4*DW-1:0]   fwdData
`endif
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    // FIFO storage and bookkeeping, one set per channel.
    logic [AW-1:0] memAddr [4][DEPTH];
    logic [DW-1:0] memData [4][DEPTH];
    logic [PW-1:0] wrPtr   [4];
    logic [PW-1:0] rdPtr   [4];
    logic [PW:0]   count   [4];

    logic [3:0]    push;
    logic [3:0]    pop;
    logic [3:0]    request;
    logic [1:0]    rrPtr;
    logic [1:0]    grantIdx;
    logic [1:0]    probe;
    logic          anyReq;
    logic [AW-1:0] headAddr;
    logic [DW-1:0] headData;

    // inReady depends only on occupancy and reset. It never looks at inValid,
    // and a pop does not open the slot until the following cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            request[i] = (count[i] != '0);
            inReady[i] = (count[i] != CNT_FULL) && rstN;
            push[i]    = inValid[i] && inReady[i];
        end
    end

    // Round-robin search starting at rrPtr: the first non-empty channel wins.
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves a value held and no latch is inferred.
    always_comb begin
        anyReq   = 1'b0;
        grantIdx = rrPtr;
        probe    = rrPtr;
        pop      = '0;
        for (int off = 0; off < 4; off++) begin
            probe = rrPtr + 2'(off);
            if (!anyReq && request[probe]) begin
                anyReq   = 1'b1;
                grantIdx = probe;
            end
        end
        if (anyReq) begin
            pop[grantIdx] = 1'b1;
        end
        headAddr = memAddr[grantIdx][rdPtr[grantIdx]];
        headData = memData[grantIdx][rdPtr[grantIdx]];
    end

    // NOTE: FIFO storage has no reset. Entries are only read once the count
    // says they are valid, and clearing the pointers is enough to discard them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                memAddr[i][wrPtr[i]] <= inAddr[i*AW +: AW];
                memData[i][wrPtr[i]] <= inData[i*DW +: DW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < 4; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
            rrPtr    <= '0;
            wrEnable <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            grant    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wrPtr[i] <= wrPtr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + PTR_ONE;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
            end

            if (anyReq) begin
                grant    <= 4'b0001 << grantIdx;
                wrAddr   <= headAddr;
                wrData   <= headData;
                // An x0 entry uses its slot but must never reach the register file.
                wrEnable <= (headAddr != '0);
                rrPtr    <= grantIdx + 2'd1;
            end else begin
                // Idle: index and data hold, so only enable and grant drop.
                wrEnable <= 1'b0;
                grant    <= '0;
            end
        end
    end

    assign busy = (|request) || wrEnable;

`ifdef WB_ARBITER_FWD_EN
    always_comb begin
        fwdHit  = '0;
        fwdData = '0;
        for (int j = 0; j < 4; j++) begin
            fwdHit[j] = wrEnable
                     && (wrAddr == fwdAddr[j*AW +: AW])
                     && (fwdAddr[j*AW +: AW] != '0);
            fwdData[j*DW +: DW] = fwdHit[j] ? wrData : '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: reset and latency, round-robin order,
// backpressure on a full channel, x0 slot consumption, forwarding (when
// WB_ARBITER_FWD_EN is defined) and reset in the middle of traffic.
// Inputs are driven and outputs sampled 1 time unit after each posedge.

module tb_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstN;
    logic [3:0]      inValid;
    logic [3:0]      inReady;
    logic [4*AW-1:0] inAddr;
    logic [4*DW-1:0] inData;
    logic            wrEnable;
    logic [AW-1:0]   wrAddr;
    logic [DW-1:0]   wrData;
    logic [3:0]      grant;
    logic            busy;
`ifdef WB_ARBITER_FWD_EN
    logic [4*AW-1:0] fwdAddr;
    logic [3:0]      fwdHit;
    logic [4*DW-1:0] fwdData;
`endif

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .inAddr   (inAddr),
        .inData   (inData),
        .wrEnable (wrEnable),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .grant    (grant),
        .busy     (busy)
`ifdef WB_ARBITER_FWD_EN
        ,
        .fwdAddr  (fwdAddr),
        .fwdHit   (fwdHit),
        .fwdData  (fwdData)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        inValid[ch]          = v;
        inAddr[ch*AW +: AW]  = a;
        inData[ch*DW +: DW]  = d;
    endtask

    task automatic expectWrite(input string tag, input logic en, input logic [3:0] g,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, ".wrEnable"}, wrEnable, en);
        check({tag, ".grant"},    grant,    g);
        check({tag, ".wrAddr"},   wrAddr,   a);
        check({tag, ".wrData"},   wrData,   d);
    endtask

    initial begin
        rstN    = 1'b0;
        inValid = '0;
        inAddr  = '0;
        inData  = '0;
`ifdef WB_ARBITER_FWD_EN
        fwdAddr = '0;
`endif

        // ---------------- reset and minimum latency ----------------
        tick();
        tick();
        expectWrite("reset", 1'b0, 4'b0000, 5'd0, 32'h0);
        check("reset.inReady", inReady, 4'b0000);
        check("reset.busy",    busy,    1'b0);

        rstN = 1'b1;
        #1;
        check("release.inReady", inReady, 4'b1111);
        drive(2, 1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();                                   // edge N: push ch2
        inValid = '0;
        check("lat.noFallThrough", wrEnable, 1'b0);
        check("lat.busyQueued",    busy,     1'b1);
        tick();                                   // edge N+1: pop
        expectWrite("lat.write", 1'b1, 4'b0100, 5'd7, 32'hDEAD_BEEF);
        tick();                                   // edge N+2: idle
        expectWrite("lat.idle", 1'b0, 4'b0000, 5'd7, 32'hDEAD_BEEF);
        check("lat.busyIdle", busy, 1'b0);

        // ---------------- round-robin over two entries per channel ----------------
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        for (int ch = 0; ch < 4; ch++) drive(ch, 1'b1, 5'(1 + 2*ch), 32'hC000_0000 + 32'(16*ch));
        tick();
        for (int ch = 0; ch < 4; ch++) drive(ch, 1'b1, 5'(2 + 2*ch), 32'hC000_0001 + 32'(16*ch));
        tick();
        inValid = '0;
        for (int s = 0; s < 8; s++) begin
            if (s != 0) tick();
            expectWrite("rr", 1'b1, 4'(1 << (s % 4)), 5'(1 + 2*(s % 4) + s/4),
                        32'hC000_0000 + 32'(16*(s % 4) + s/4));
        end
        tick();
        check("rr.endEnable", wrEnable, 1'b0);
        check("rr.endBusy",   busy,     1'b0);

        // One ch0 pop moves the rr pointer to 1 for the backpressure test.
        drive(0, 1'b1, 5'd31, 32'h0BAD_0000);
        tick();
        inValid = '0;
        tick();
        expectWrite("prep", 1'b1, 4'b0001, 5'd31, 32'h0BAD_0000);
        tick();
        check("prep.idle", wrEnable, 1'b0);

        // ---------------- full channel and backpressure ----------------
        drive(0, 1'b1, 5'd10, 32'hF000_0000);
        drive(1, 1'b1, 5'd21, 32'h21);
        drive(2, 1'b1, 5'd22, 32'h22);
        drive(3, 1'b1, 5'd23, 32'h23);
        tick();                                   // P1
        check("full.readyP1", inReady, 4'b1111);
        inValid[3:1] = 3'b000;
        drive(0, 1'b1, 5'd11, 32'hF000_0001);
        tick();                                   // P2
        expectWrite("full.ch1", 1'b1, 4'b0010, 5'd21, 32'h21);
        drive(0, 1'b1, 5'd12, 32'hF000_0002);
        tick();                                   // P3
        expectWrite("full.ch2", 1'b1, 4'b0100, 5'd22, 32'h22);
        drive(0, 1'b1, 5'd13, 32'hF000_0003);
        tick();                                   // P4: ch0 now holds 4
        expectWrite("full.ch3", 1'b1, 4'b1000, 5'd23, 32'h23);
        check("full.readyLow", inReady, 4'b1110);
        drive(0, 1'b1, 5'd14, 32'hF000_0004);     // 5th entry, must be refused
        tick();                                   // P5: first ch0 pop
        inValid = '0;
        expectWrite("full.e0", 1'b1, 4'b0001, 5'd10, 32'hF000_0000);
        check("full.readyBack", inReady, 4'b1111);
        for (int k = 1; k < 4; k++) begin
            tick();
            expectWrite("full.order", 1'b1, 4'b0001, 5'(10 + k), 32'hF000_0000 + 32'(k));
        end
        tick();
        check("full.no5th",   wrEnable, 1'b0);
        check("full.endBusy", busy,     1'b0);

        // ---------------- x0 consumes its slot ----------------
        drive(1, 1'b1, 5'd0, 32'h1234);
        tick();
        drive(1, 1'b1, 5'd3, 32'h55);
        tick();
        inValid = '0;
        expectWrite("x0.drop", 1'b0, 4'b0010, 5'd0, 32'h1234);
        tick();
        expectWrite("x0.next", 1'b1, 4'b0010, 5'd3, 32'h55);
        tick();
        expectWrite("x0.idleHold", 1'b0, 4'b0000, 5'd3, 32'h55);

        // ---------------- forwarding compare ----------------
`ifdef WB_ARBITER_FWD_EN
        fwdAddr = {5'd4, 5'd9, 5'd0, 5'd9};       // slots 3..0 = 4, 9, 0, 9
`endif
        drive(2, 1'b1, 5'd9, 32'hA5A5_A5A5);
        tick();
        drive(2, 1'b1, 5'd0, 32'h77);
        tick();
        inValid = '0;
        expectWrite("fwd.write", 1'b1, 4'b0100, 5'd9, 32'hA5A5_A5A5);
`ifdef WB_ARBITER_FWD_EN
        check("fwd.hit",   fwdHit,            4'b0101);
        check("fwd.data0", fwdData[0*DW +: DW], 32'hA5A5_A5A5);
        check("fwd.data1", fwdData[1*DW +: DW], 32'h0);
        check("fwd.data2", fwdData[2*DW +: DW], 32'hA5A5_A5A5);
        check("fwd.data3", fwdData[3*DW +: DW], 32'h0);
`endif
        tick();
        expectWrite("fwd.x0", 1'b0, 4'b0100, 5'd0, 32'h77);
`ifdef WB_ARBITER_FWD_EN
        check("fwd.x0Hit",  fwdHit,  4'b0000);
        check("fwd.x0Data", fwdData, '0);
`endif
        tick();
        check("fwd.idle", wrEnable, 1'b0);

        // ---------------- reset in the middle of traffic ----------------
        // rr pointer is 3 here, so ch3 goes first.
        drive(0, 1'b1, 5'd1, 32'h100);
        drive(3, 1'b1, 5'd2, 32'h300);
        tick();
        drive(0, 1'b1, 5'd3, 32'h101);
        drive(3, 1'b1, 5'd4, 32'h301);
        tick();
        expectWrite("mid.ch3", 1'b1, 4'b1000, 5'd2, 32'h300);
        drive(0, 1'b1, 5'd5, 32'h102);
        drive(3, 1'b1, 5'd6, 32'h302);
        tick();
        expectWrite("mid.ch0", 1'b1, 4'b0001, 5'd1, 32'h100);
        inValid = '0;
        rstN    = 1'b0;
        #1;
        check("mid.readyInReset", inReady, 4'b0000);
        tick();
        expectWrite("mid.reset", 1'b0, 4'b0000, 5'd0, 32'h0);
        check("mid.busyReset", busy, 1'b0);
        rstN = 1'b1;
        #1;
        check("mid.readyRelease", inReady, 4'b1111);
        tick();
        check("mid.noResidue",  wrEnable, 1'b0);
        check("mid.busyAfter",  busy,     1'b0);
        drive(0, 1'b1, 5'd7, 32'h70);
        drive(3, 1'b1, 5'd8, 32'h80);
        tick();
        inValid = '0;
        tick();
        expectWrite("mid.rrZero", 1'b1, 4'b0001, 5'd7, 32'h70);
        tick();
        expectWrite("mid.then3",  1'b1, 4'b1000, 5'd8, 32'h80);
        tick();
        check("mid.endEnable", wrEnable, 1'b0);
        check("mid.endBusy",   busy,     1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
